// File: rtl/paver_ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its companion receiver:
// state encoding, frame geometry and the common keyboard command bytes.
package paver_ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam int FRAME_BITS         = 10;
  localparam int DEFAULT_FILTER_LEN = 8;

  localparam logic [7:0] CMD_LEDS   = 8'hED;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // Wire order LSB first: 8 data bits, odd parity, stop bit.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/paver_ps2_clkfilter.sv
// Synchronises the PS/2 pins and debounces the clock into a clean level plus
// a one-cycle falling-edge pulse; shared with the receiver so both see the same edges.
module paver_ps2_clkfilter
  import paver_ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk,
  input  logic ps2data,
  output logic cleanclk,
  output logic negedge_pulse,
  output logic data_sync
);

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] history;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync      <= '0;
      dat_sync      <= '0;
      history       <= '0;
      cleanclk      <= 1'b0;
      negedge_pulse <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2data};
      history  <= {history[FILTER_LEN-2:0], clk_sync[1]};
      // NOTE: the pulse defaults low with a non-blocking write first, so a later
      // assignment in the same block wins and no stale value lingers.
      negedge_pulse <= 1'b0;
      if (&history) begin
        cleanclk <= 1'b1;
      end else if (~|history && cleanclk) begin
        cleanclk      <= 1'b0;
        negedge_pulse <= 1'b1;
      end
    end
  end

  assign data_sync = dat_sync[1];

endmodule

// File: rtl/paver_ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, shifts a
// command byte out on device clock edges and reports whether the device ACKed.
module paver_ps2_tx
  import paver_ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN
) (
  input  logic       coreclk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_low,
  output logic       ps2data_low,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       rx_inhibit
);

  localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int IDLE_W    = $clog2(FILTER_LEN + 1);

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_BIT_AT = TIMER_W'(INHIBIT_CYCLES - 2);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST    = IDLE_W'(FILTER_LEN - 1);
  localparam logic [3:0]         LAST_BIT     = 4'(FRAME_BITS - 1);

  state_t                  state;
  logic [FRAME_BITS-1:0]   frame;
  logic [3:0]              bit_cnt;
  logic [TIMER_W-1:0]      timer;
  logic [IDLE_W-1:0]       idle_cnt;
  logic                    cleanclk;
  logic                    negedge_pulse;
  logic                    data_sync;
  logic                    timed_out;

  paver_ps2_clkfilter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clkfilter (
    .clk           (coreclk),
    .rst_n         (reset),
    .ps2clk        (ps2clk),
    .ps2data       (ps2data),
    .cleanclk      (cleanclk),
    .negedge_pulse (negedge_pulse),
    .data_sync     (data_sync)
  );

  // The timeout window opens when the clock line is released and covers the ACK.
  assign timed_out = (state == START || state == ACK || state == WAIT_IDLE) &&
                     (timer == TIMEOUT_LAST);

  always_ff @(posedge coreclk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      idle_cnt    <= '0;
      ps2clk_low  <= 1'b0;
      ps2data_low <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            frame      <= build_frame(tx_data);
            bit_cnt    <= '0;
            timer      <= '0;
            idle_cnt   <= '0;
            ack_ok     <= 1'b0;
            busy       <= 1'b1;
            ps2clk_low <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          timer <= timer + 1'b1;
          if (timer == START_BIT_AT) ps2data_low <= 1'b1;
          if (timer == INHIBIT_LAST) begin
            ps2clk_low <= 1'b0;
            timer      <= '0;
            state      <= START;
          end
        end
        START: begin
          timer <= timer + 1'b1;
          if (negedge_pulse) begin
            ps2data_low <= ~frame[0];
            frame       <= frame >> 1;
            if (bit_cnt == LAST_BIT) state <= ACK;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ACK: begin
          timer <= timer + 1'b1;
          if (negedge_pulse) begin
            ack_ok   <= ~data_sync;
            idle_cnt <= '0;
            state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          timer <= timer + 1'b1;
          if (cleanclk && data_sync) begin
            if (idle_cnt == IDLE_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (timed_out) begin
        ps2clk_low  <= 1'b0;
        ps2data_low <= 1'b0;
        ack_ok      <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        state       <= DONE;
      end
    end
  end

  assign rx_inhibit = busy;

endmodule

// File: tb/tb_paver_ps2_tx.sv
// Self-checking bench for paver_ps2_tx: a behavioural PS/2 device on a wired-AND
// bus clocks frames out of the host and compares them with a frame model.
module tb_paver_ps2_tx;
  import paver_ps2_pkg::*;

  localparam int INH = 1000;
  localparam int TMO = 2000;
  localparam int FLT = 8;

  logic       coreclk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2clk_low, ps2data_low, busy, done, ack_ok, rx_inhibit;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk_line, ps2data_line;

  int checks = 0;
  int errors = 0;

  assign ps2clk_line  = ~(ps2clk_low | dev_clk_low);
  assign ps2data_line = ~(ps2data_low | dev_data_low);

  paver_ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLT)
  ) dut (
    .coreclk     (coreclk),
    .reset       (reset),
    .ps2clk      (ps2clk_line),
    .ps2data     (ps2data_line),
    .ps2clk_low  (ps2clk_low),
    .ps2data_low (ps2data_low),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .rx_inhibit  (rx_inhibit)
  );

  always #5 coreclk = ~coreclk;

  // Observers: latch what the DUT showed on each done pulse, and watch bus ownership.
  int   done_cnt = 0;
  logic done_ack, done_busy, done_prev_busy;
  logic prev_busy = 1'b0;
  int   own_viol = 0;
  int   rxi_viol = 0;

  always @(negedge coreclk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_ack       = ack_ok;
      done_busy      = busy;
      done_prev_busy = prev_busy;
    end
    if (busy !== 1'b1 && (ps2clk_low !== 1'b0 || ps2data_low !== 1'b0)) own_viol++;
    if (rx_inhibit !== busy) rxi_viol++;
    prev_busy = busy;
  end

  // Reference frame: data LSB first, parity makes the total count of ones odd, stop = 1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Device side of one transfer; returns what the device observed.
  task automatic run_frame(input logic [7:0] data, input int half, input bit dev_ack,
                           input bit glitch, output int inh_len, output int dl_cycles,
                           output bit start_low, output logic [9:0] seen, output bit got_done);
    int c0, n;
    c0 = done_cnt;
    seen = '0;
    @(negedge coreclk); tx_data = data; tx_start = 1'b1;
    @(negedge coreclk); tx_start = 1'b0;
    inh_len = 0;
    dl_cycles = 0;
    while (ps2clk_low === 1'b1 && inh_len < INH + 50) begin
      inh_len++;
      if (ps2data_low === 1'b1) dl_cycles++;
      @(negedge coreclk);
    end
    start_low = (ps2data_low === 1'b1);
    repeat (half) @(negedge coreclk);
    for (int k = 0; k < 11; k++) begin
      if (k == 10) dev_data_low = dev_ack;
      dev_clk_low = 1'b1;
      repeat (half) @(negedge coreclk);
      dev_clk_low = 1'b0;
      if (k < 10) seen[k] = ps2data_line;
      if (glitch && k == 3) begin
        repeat (half / 2) @(negedge coreclk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge coreclk);
        dev_clk_low = 1'b0;
        repeat (half - half / 2 - 3) @(negedge coreclk);
      end else begin
        repeat (half) @(negedge coreclk);
      end
    end
    dev_data_low = 1'b0;
    n = 0;
    while (done_cnt == c0 && n < 300) begin
      @(negedge coreclk); #1;
      n++;
    end
    got_done = (done_cnt != c0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge coreclk);
    checks++;
    if ({ps2clk_low, ps2data_low, busy, done, ack_ok, rx_inhibit} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {ps2clk_low, ps2data_low, busy, done, ack_ok, rx_inhibit});
    end
    reset = 1'b1;
    repeat (20) @(negedge coreclk);
  endtask

  task automatic test_send_leds;
    int inh, dl; bit sl, gd; logic [9:0] seen;
    run_frame(CMD_LEDS, 20, 1'b1, 1'b0, inh, dl, sl, seen, gd);
    checks++;
    if (inh != INH) begin errors++; $display("FAIL leds_inhibit_len: got %0d expected %0d", inh, INH); end
    checks++;
    if (dl != 1) begin errors++; $display("FAIL leds_start_in_inhibit: got %0d expected 1", dl); end
    checks++;
    if (!sl) begin errors++; $display("FAIL leds_start_bit: got 0 expected 1"); end
    checks++;
    if (seen !== model_frame(CMD_LEDS)) begin
      errors++; $display("FAIL leds_bits: got %b expected %b", seen, model_frame(CMD_LEDS));
    end
    checks++;
    if (!gd) begin errors++; $display("FAIL leds_done: got none expected pulse"); end
    checks++;
    if ({done_ack, done_busy, done_prev_busy} !== 3'b101) begin
      errors++; $display("FAIL leds_ack_busy: got %b expected 101", {done_ack, done_busy, done_prev_busy});
    end
    // ack_ok must hold after the pulse
    repeat (10) @(negedge coreclk);
    checks++;
    if (ack_ok !== 1'b1) begin errors++; $display("FAIL leds_ack_hold: got %b expected 1", ack_ok); end
  endtask

  task automatic test_parity;
    logic [7:0] bytes [3];
    logic       par [3];
    int inh, dl; bit sl, gd; logic [9:0] seen;
    bytes = '{8'h01, 8'hFF, 8'h00};
    par   = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_frame(bytes[i], 18, 1'b1, 1'b0, inh, dl, sl, seen, gd);
      checks++;
      if (seen[8] !== par[i]) begin
        errors++; $display("FAIL parity_%h: got %b expected %b", bytes[i], seen[8], par[i]);
      end
      checks++;
      if (seen !== model_frame(bytes[i]) || !gd || done_ack !== 1'b1) begin
        errors++;
        $display("FAIL parity_frame_%h: got bits %b done %0d ack %b expected bits %b done 1 ack 1",
                 bytes[i], seen, gd, done_ack, model_frame(bytes[i]));
      end
    end
  endtask

  task automatic test_timeout;
    int n;
    @(negedge coreclk); tx_data = CMD_RESET; tx_start = 1'b1;
    @(negedge coreclk); tx_start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < INH + TMO + 50) begin
      @(negedge coreclk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || n < INH + TMO || n > INH + TMO + 2) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", n, INH + TMO, INH + TMO + 2);
    end
    checks++;
    if ({ack_ok, busy} !== 2'b00) begin
      errors++; $display("FAIL timeout_ack_busy: got %b expected 00", {ack_ok, busy});
    end
    repeat (5) @(negedge coreclk);
    checks++;
    if ({ps2clk_low, ps2data_low} !== 2'b00) begin
      errors++; $display("FAIL timeout_lines: got %b expected 00", {ps2clk_low, ps2data_low});
    end
  endtask

  task automatic test_nack;
    int inh, dl; bit sl, gd; logic [9:0] seen;
    run_frame(8'h5A, 22, 1'b0, 1'b0, inh, dl, sl, seen, gd);
    checks++;
    if (seen !== model_frame(8'h5A) || !gd || done_ack !== 1'b0 || done_busy !== 1'b0) begin
      errors++;
      $display("FAIL nack: got bits %b done %0d ack %b busy %b expected bits %b done 1 ack 0 busy 0",
               seen, gd, done_ack, done_busy, model_frame(8'h5A));
    end
  endtask

  task automatic test_glitch;
    int inh, dl; bit sl, gd; logic [9:0] seen;
    run_frame(CMD_ENABLE, 24, 1'b1, 1'b1, inh, dl, sl, seen, gd);
    checks++;
    if (seen !== model_frame(CMD_ENABLE) || !gd || done_ack !== 1'b1) begin
      errors++;
      $display("FAIL glitch: got bits %b done %0d ack %b expected bits %b done 1 ack 1",
               seen, gd, done_ack, model_frame(CMD_ENABLE));
    end
  endtask

  task automatic test_reset_midframe;
    int n, inh, dl; bit sl, gd; logic [9:0] seen;
    @(negedge coreclk); tx_data = 8'h00; tx_start = 1'b1;
    @(negedge coreclk); tx_start = 1'b0;
    n = 0;
    while (ps2clk_low === 1'b1 && n < INH + 50) begin @(negedge coreclk); n++; end
    repeat (20) @(negedge coreclk);
    for (int k = 0; k < 5; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge coreclk);
      dev_clk_low = 1'b0;
      if (k < 4) repeat (20) @(negedge coreclk);
    end
    repeat (10) @(negedge coreclk);
    checks++;
    if ({busy, ps2data_low} !== 2'b11) begin
      errors++; $display("FAIL midframe_bit4: got busy,data_low %b expected 11", {busy, ps2data_low});
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({ps2clk_low, ps2data_low, busy, rx_inhibit} !== 4'b0000) begin
      errors++; $display("FAIL midframe_async_release: got %b expected 0000",
                         {ps2clk_low, ps2data_low, busy, rx_inhibit});
    end
    @(negedge coreclk); reset = 1'b1;
    repeat (30) @(negedge coreclk);
    run_frame(CMD_ENABLE, 20, 1'b1, 1'b0, inh, dl, sl, seen, gd);
    checks++;
    if (seen !== model_frame(CMD_ENABLE) || !gd || done_ack !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_f4: got bits %b done %0d ack %b expected bits %b done 1 ack 1",
               seen, gd, done_ack, model_frame(CMD_ENABLE));
    end
  endtask

  task automatic test_random;
    int inh, dl, half; bit sl, gd, ack; logic [9:0] seen; logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom);
      half = int'($urandom_range(16, 30));
      ack  = 1'($urandom_range(0, 1));
      run_frame(b, half, ack, 1'b0, inh, dl, sl, seen, gd);
      checks++;
      if (seen !== model_frame(b) || !gd || done_ack !== ack || inh != INH) begin
        errors++;
        $display("FAIL random_%0d: got bits %b done %0d ack %b inh %0d expected bits %b done 1 ack %b inh %0d",
                 i, seen, gd, done_ack, inh, model_frame(b), ack, INH);
      end
    end
  endtask

  task automatic test_back_to_back;
    int inh, dl; bit sl, gd; logic [9:0] seen;
    // ack_ok is 1 from the previous ACKed frame; a new accept clears it, and a
    // second tx_start during the transfer is ignored.
    fork
      run_frame(8'hA6, 20, 1'b0, 1'b0, inh, dl, sl, seen, gd);
      begin
        repeat (3) @(negedge coreclk);
        checks++;
        if ({ack_ok, busy} !== 2'b01) begin
          errors++; $display("FAIL b2b_ack_clear: got ack,busy %b expected 01", {ack_ok, busy});
        end
        repeat (50) @(negedge coreclk);
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge coreclk); tx_start = 1'b0;
      end
    join
    checks++;
    if (seen !== model_frame(8'hA6) || !gd || done_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frame: got bits %b done %0d ack %b expected bits %b done 1 ack 0",
               seen, gd, done_ack, model_frame(8'hA6));
    end
    repeat (20) @(negedge coreclk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_start: got busy %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_send_leds();
    test_parity();
    test_random();
    test_back_to_back();
    test_timeout();
    test_nack();
    test_glitch();
    test_reset_midframe();
    checks++;
    if (own_viol != 0) begin errors++; $display("FAIL line_ownership: got %0d violations expected 0", own_viol); end
    checks++;
    if (rxi_viol != 0) begin errors++; $display("FAIL rx_inhibit_eq_busy: got %0d violations expected 0", rxi_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
